// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter and its LSU result queue.
// Imported by every wb_* file.
package wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LSU_DEPTH  = 2;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  function automatic logic rd_live_hit(
    input logic                  live,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] chk
  );
    return live && (chk != REG_X0) && (rd == chk);
  endfunction
endpackage

// File: rtl/wb_lsu_fifo.sv
// LSU result queue: {live, rd, wd} entries drained in order,
// with per-entry squash by younger ALU writes and pending-rd lookup.
module wb_lsu_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int W     = XLEN,
  parameter int RW    = REG_ADDR_W,
  parameter int DEPTH = LSU_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [RW-1:0] i_push_rd,
  input  logic [W-1:0]  i_push_wd,
  input  logic          i_pop,
  input  logic          i_sq_en,
  input  logic [RW-1:0] i_sq_rd,
  input  logic [RW-1:0] i_chk_rs1,
  input  logic [RW-1:0] i_chk_rs2,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_head_live,
  output logic [RW-1:0] o_head_rd,
  output logic [W-1:0]  o_head_wd,
  output logic          o_pend_hit
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          r_live [DEPTH];
  logic [RW-1:0] r_rd   [DEPTH];
  logic [W-1:0]  r_wd   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_hit;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_live = r_live[r_head];
  assign o_head_rd   = r_rd[r_head];
  assign o_head_wd   = r_wd[r_head];
  assign o_pend_hit  = w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // Free slots are kept dead, so live alone qualifies squash and lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_live[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && r_tail == PW'(i))
          r_live[i] <= 1'b1;
        else if (i_pop && r_head == PW'(i))
          r_live[i] <= 1'b0;
        else if (i_sq_en && r_rd[i] == i_sq_rd)
          r_live[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_push && r_tail == PW'(i)) begin
        r_rd[i] <= i_push_rd;
        r_wd[i] <= i_push_wd;
      end
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_live_hit(r_live[i], r_rd[i], i_chk_rs1) ||
          rd_live_hit(r_live[i], r_rd[i], i_chk_rs2))
        w_hit = 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win the reg_file port,
// queued LSU results fill the free slots in order.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN_P     = XLEN,
  parameter int REG_ADDR_P = REG_ADDR_W,
  parameter int LSU_DEPTH_P = LSU_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_P-1:0] alu_rd,
  input  logic [XLEN_P-1:0]     alu_wd,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_P-1:0] lsu_rd,
  input  logic [XLEN_P-1:0]     lsu_wd,
  input  logic [REG_ADDR_P-1:0] chk_rs1,
  input  logic [REG_ADDR_P-1:0] chk_rs2,
  output logic                  pend_hit,
  output logic                  reg_write,
  output logic [REG_ADDR_P-1:0] rd,
  output logic [XLEN_P-1:0]     wd
);
  logic                  w_alu_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_head_live;
  logic [REG_ADDR_P-1:0] w_head_rd;
  logic [XLEN_P-1:0]     w_head_wd;
  logic                  r_reg_write;
  logic [REG_ADDR_P-1:0] r_rd;
  logic [XLEN_P-1:0]     r_wd;

  assign w_alu_req = alu_valid && (alu_rd != '0);
  assign lsu_ready = !w_full;
  assign w_push    = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign w_pop     = !w_alu_req && !w_empty;

  wb_lsu_fifo #(
    .W     (XLEN_P),
    .RW    (REG_ADDR_P),
    .DEPTH (LSU_DEPTH_P)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_rd   (lsu_rd),
    .i_push_wd   (lsu_wd),
    .i_pop       (w_pop),
    .i_sq_en     (w_alu_req),
    .i_sq_rd     (alu_rd),
    .i_chk_rs1   (chk_rs1),
    .i_chk_rs2   (chk_rs2),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_live (w_head_live),
    .o_head_rd   (w_head_rd),
    .o_head_wd   (w_head_wd),
    .o_pend_hit  (pend_hit)
  );

  // A dead head still pops, leaving a bubble with rd/wd held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wd        <= '0;
    end else if (w_alu_req) begin
      r_reg_write <= 1'b1;
      r_rd        <= alu_rd;
      r_wd        <= alu_wd;
    end else if (w_pop && w_head_live) begin
      r_reg_write <= 1'b1;
      r_rd        <= w_head_rd;
      r_wd        <= w_head_wd;
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  assign reg_write = r_reg_write;
  assign rd        = r_rd;
  assign wd        = r_wd;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a queue-based
// model of the write-back ordering rules.
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_wd = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_wd = '0;
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic        pend_hit;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] wd;

  wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_wd    (lsu_wd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .pend_hit  (pend_hit),
    .reg_write (reg_write),
    .rd        (rd),
    .wd        (wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic model_hit(logic [4:0] c1, logic [4:0] c2);
    foreach (mq[i])
      if (mq[i].live && ((c1 != 0 && mq[i].rd == c1) || (c2 != 0 && mq[i].rd == c2)))
        return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every write must be the next scoreboard entry, on its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_write) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 64'(rd), 64'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.cyc));
          check("write_rd", 64'(rd), 64'(e.rd));
          check("write_wd", 64'(wd), 64'(e.wd));
        end
        check("x0_never_written", 64'(rd != 0), 64'(1));
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        check("missing_write", 64'(0), 64'(sb[0].rd));
        void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                      input logic [4:0] c1, input logic [4:0] c2);
    logic alu_req;
    logic acc;
    ent_t h;
    @(posedge clk);
    #1;
    alu_valid = av; alu_rd = ard; alu_wd = awd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
    chk_rs1 = c1; chk_rs2 = c2;
    #1;
    check("lsu_ready", 64'(lsu_ready), 64'(mq.size() < DEPTH));
    check("pend_hit", 64'(pend_hit), 64'(model_hit(c1, c2)));
    alu_req = av && ard != 0;
    acc = lv && (mq.size() < DEPTH);
    if (alu_req) begin
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      sb.push_back('{cyc + 1, ard, awd});
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      if (h.live) sb.push_back('{cyc + 1, h.rd, h.wd});
    end
    if (acc && lrd != 0) mq.push_back('{1'b1, lrd, lwd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #3;
    check("rst_reg_write", 64'(reg_write), 64'(0));
    check("rst_rd", 64'(rd), 64'(0));
    check("rst_wd", 64'(wd), 64'(0));
    check("rst_lsu_ready", 64'(lsu_ready), 64'(1));
    check("rst_pend_hit", 64'(pend_hit), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    step(1, 1, 32'hABCD1234, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 5, 32'h11111111, 5, 0);
    idle(3);
    step(1, 9, 32'h9, 1, 6, 32'h66666666, 6, 0);
    step(1, 10, 32'hA, 1, 7, 32'h77777777, 7, 6);
    step(1, 11, 32'hB, 1, 8, 32'h88888888, 0, 0);
    idle(4);
    step(0, 0, 0, 1, 3, 32'h33333333, 3, 0);
    step(1, 3, 32'h22222222, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    idle(2);
    step(1, 12, 32'hC, 1, 4, 32'h44444444, 0, 4);
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 4);
    idle(2);
    step(0, 0, 0, 1, 0, 32'h12345678, 0, 0);
    idle(2);

    step(1, 13, 32'hD, 1, 14, 32'hE, 0, 0);
    step(1, 15, 32'hF, 1, 16, 32'h10, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_reg_write", 64'(reg_write), 64'(0));
    check("midrst_lsu_ready", 64'(lsu_ready), 64'(1));
    chk_rs1 = 14; chk_rs2 = 16;
    #1;
    check("midrst_pend_hit", 64'(pend_hit), 64'(0));
    mq.delete();
    sb.delete();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 14, 16);
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      int pa;
      pa = (n < 1500) ? 70 : 30;
      step(($urandom_range(0, 99) < pa) ? 1'b1 : 1'b0,
           5'($urandom_range(0, 7)), 32'($urandom()),
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           5'($urandom_range(0, 7)), 32'($urandom()),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
